// File: rtl/regfile_debug_ctrl_if.sv
// Debug stream carrying register-file dump words from the controller to a consumer.
// A word transfers on any rising edge where dbg_valid and dbg_ready are both high.
interface regfile_debug_ctrl_if #(
    parameter int width_B = 32,
    parameter int Addr_B  = 5
);
    logic               dbg_valid;
    logic               dbg_ready;
    logic [Addr_B-1:0]  dbg_addr;
    logic [width_B-1:0] dbg_data;

    modport master (
        output dbg_valid,
        output dbg_addr,
        output dbg_data,
        input  dbg_ready
    );

    modport slave (
        input  dbg_valid,
        input  dbg_addr,
        input  dbg_data,
        output dbg_ready
    );
endinterface

// File: rtl/regfile_debug_ctrl.sv
// Borrows register-file read port 1 from the pipeline and streams every register out.
// Optional trailing XOR checksum word when REGFILE_DEBUG_CSUM_EN is defined.
module regfile_debug_ctrl #(
    parameter int width_B = 32,
    parameter int Addr_B  = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                dump_req,
    input  logic [Addr_B-1:0]   pipe_Read_Addr_1,
    output logic [Addr_B-1:0]   rf_Read_Addr_1,
    input  logic [width_B-1:0]  rf_Read_Data_1,
    output logic                pipe_stall,
    regfile_debug_ctrl_if.master dbg,
    output logic                dump_busy,
    output logic                dump_done
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STALL,
        ST_READ,
        ST_SEND,
`ifdef REGFILE_DEBUG_CSUM_EN
        ST_CSUM,
`endif
        ST_DONE
    } state_t;

    localparam logic [Addr_B-1:0] IDX_LAST = '1;

    state_t             state_q, state_d;
    logic [Addr_B-1:0]  idx_q, idx_d;
    logic [Addr_B-1:0]  dbg_addr_q, dbg_addr_d;
    logic [width_B-1:0] dbg_data_q, dbg_data_d;
    logic               dbg_valid_q, dbg_valid_d;
    logic               pipe_stall_q, pipe_stall_d;
    logic               dump_busy_q, dump_busy_d;
    logic               dump_done_q, dump_done_d;
`ifdef REGFILE_DEBUG_CSUM_EN
    logic [width_B-1:0] acc_q, acc_d;
`endif

    // The pipeline keeps port 1 whenever the controller is idle.
    assign rf_Read_Addr_1 = (state_q == ST_IDLE) ? pipe_Read_Addr_1 : idx_q;

    assign pipe_stall    = pipe_stall_q;
    assign dump_busy     = dump_busy_q;
    assign dump_done     = dump_done_q;
    assign dbg.dbg_valid = dbg_valid_q;
    assign dbg.dbg_addr  = dbg_addr_q;
    assign dbg.dbg_data  = dbg_data_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        dbg_addr_d = dbg_addr_q;
        dbg_data_d = dbg_data_q;
`ifdef REGFILE_DEBUG_CSUM_EN
        acc_d      = acc_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (dump_req) begin
                    state_d = ST_STALL;
`ifdef REGFILE_DEBUG_CSUM_EN
                    acc_d   = '0;
`endif
                end
            end
            ST_STALL: begin
                state_d = ST_READ;
            end
            ST_READ: begin
                dbg_data_d = rf_Read_Data_1;
                dbg_addr_d = idx_q;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (dbg.dbg_ready) begin
`ifdef REGFILE_DEBUG_CSUM_EN
                    acc_d = acc_q ^ dbg_data_q;
`endif
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
`ifdef REGFILE_DEBUG_CSUM_EN
                        // Checksum covers the word leaving on this very handshake.
                        dbg_data_d = acc_q ^ dbg_data_q;
                        dbg_addr_d = '0;
                        state_d    = ST_CSUM;
`else
                        state_d    = ST_DONE;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_READ;
                    end
                end
            end
`ifdef REGFILE_DEBUG_CSUM_EN
            ST_CSUM: begin
                if (dbg.dbg_ready) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered copies of the next-state decode.
`ifdef REGFILE_DEBUG_CSUM_EN
        dbg_valid_d  = (state_d == ST_SEND) || (state_d == ST_CSUM);
`else
        dbg_valid_d  = (state_d == ST_SEND);
`endif
        pipe_stall_d = (state_d != ST_IDLE);
        dump_busy_d  = (state_d != ST_IDLE);
        dump_done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            dbg_addr_q   <= '0;
            dbg_data_q   <= '0;
            dbg_valid_q  <= 1'b0;
            pipe_stall_q <= 1'b0;
            dump_busy_q  <= 1'b0;
            dump_done_q  <= 1'b0;
`ifdef REGFILE_DEBUG_CSUM_EN
            acc_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            dbg_addr_q   <= dbg_addr_d;
            dbg_data_q   <= dbg_data_d;
            dbg_valid_q  <= dbg_valid_d;
            pipe_stall_q <= pipe_stall_d;
            dump_busy_q  <= dump_busy_d;
            dump_done_q  <= dump_done_d;
`ifdef REGFILE_DEBUG_CSUM_EN
            acc_q        <= acc_d;
`endif
        end
    end

endmodule
